// File: rtl/encoder_8_3_seq_pkg.sv
// Shared types and sizes for the sequential 8-to-3 priority encoder.
// Holds the two-state output FSM encoding and request/index widths.
package enc_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/encoder_8_3_seq_prio.sv
// Combinational fixed-priority pick over the pending-request vector.
// LOW_FIRST=0 favours bit 7, LOW_FIRST=1 favours bit 0; idx is 0 when nothing is set.
module prio_enc_8_3
  import enc_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [N_REQ-1:0] onehot
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (LOW_FIRST) begin
        if (req[N_REQ-1-i]) idx = IDX_W'(N_REQ - 1 - i);
      end else begin
        if (req[i]) idx = IDX_W'(i);
      end
    end
    any    = |req;
    onehot = any ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/encoder_8_3_seq.sv
// Registered priority encoder: requests collect in a pending register and are served
// one index per accepted handshake; merged repeats of a still-pending bit raise sticky ovf.
module encoder_8_3_seq
  import enc_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_REQ-1:0]      I,
  input  logic                  ready,
  input  logic                  clr_ovf,
  output logic [IDX_W-1:0]      D,
  output logic                  valid,
  output logic [N_REQ-1:0]      pend,
  output logic                  ovf
);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   p_q, p_d;
  logic [IDX_W-1:0]   d_q, d_d;
  logic               ovf_q, ovf_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [N_REQ-1:0]   pick_onehot;
  logic [N_REQ-1:0]   take;
  logic [N_REQ-1:0]   req_in;
  logic               load;
  logic               ovf_set;

  // The pick sees only the registered P, so same-edge captures wait a cycle.
  prio_enc_8_3 #(.LOW_FIRST(LOW_FIRST)) u_prio (
    .req    (p_q),
    .idx    (pick_idx),
    .any    (pick_any),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    take    = '0;
    load    = (state_q == IDLE) || ready;
    req_in  = en ? I : '0;

    case (state_q)
      IDLE:    if (pick_any) state_d = HOLD;
      HOLD:    if (ready) state_d = pick_any ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      d_d  = pick_any ? pick_idx : '0;
      take = pick_onehot;
    end

    p_d     = (p_q & ~take) | req_in;
    ovf_set = |(req_in & p_q & ~take);
    ovf_d   = ovf_set | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      d_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      d_q     <= d_d;
      ovf_q   <= ovf_d;
    end
  end

  assign D     = d_q;
  assign valid = (state_q == HOLD);
  assign pend  = p_q;
  assign ovf   = ovf_q;

endmodule
